// File: rtl/fp_unpk.sv
// fp_unpk: unpacks an IEEE-754 single/double operand into sign, exponent,
// mantissa and fclass-style classification, normalizing subnormals over
// several cycles with an 8-bit leading-zero window.
module fp_unpk (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [1:0]  in_fmt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sig,
    output logic [13:0] out_expo,
    output logic [53:0] out_mant,
    output logic [9:0]  out_class,
    output logic        out_snan,
    output logic        out_qnan,
    output logic        out_inf,
    output logic        out_zero
);

    localparam int unsigned EW = 14;
    localparam int unsigned MW = 54;
    localparam int unsigned CW = 10;

    localparam logic [MW-1:0] HID_S = MW'(1) << 23;
    localparam logic [MW-1:0] HID_D = MW'(1) << 52;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t          state_q, state_d;
    logic            dbl_q, dbl_d;
    logic            sig_q, sig_d;
    logic [EW-1:0]   expo_q, expo_d;
    logic [MW-1:0]   mant_q, mant_d;
    logic [CW-1:0]   class_q, class_d;
    logic            snan_q, snan_d, qnan_q, qnan_d;
    logic            inf_q, inf_d, zero_q, zero_d;
    logic            valid_q, valid_d;

    logic            dbl_c, sgn_c, fmsb_c;
    logic [10:0]     ex_c, emax_c;
    logic [51:0]     fr_c;
    logic [7:0]      win;
    logic [3:0]      sh;

    // Leading-zero count of an 8-bit window (8 when the window is empty).
    function automatic logic [3:0] lz8(input logic [7:0] w);
        lz8 = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) lz8 = 4'(7 - i);
        end
    endfunction

    assign in_ready  = (state_q == IDLE) & ~reset;
    assign out_valid = valid_q;
    assign out_sig   = sig_q;
    assign out_expo  = expo_q;
    assign out_mant  = mant_q;
    assign out_class = class_q;
    assign out_snan  = snan_q;
    assign out_qnan  = qnan_q;
    assign out_inf   = inf_q;
    assign out_zero  = zero_q;

    // Field extraction for the incoming operand; fmt 2/3 fall back to single.
    always_comb begin
        dbl_c = (in_fmt == 2'd1);
        if (dbl_c) begin
            sgn_c  = in_data[63];
            ex_c   = in_data[62:52];
            fr_c   = in_data[51:0];
            emax_c = 11'h7FF;
            fmsb_c = in_data[51];
        end else begin
            sgn_c  = in_data[31];
            ex_c   = 11'(in_data[30:23]);
            fr_c   = 52'(in_data[22:0]);
            emax_c = 11'h0FF;
            fmsb_c = in_data[22];
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d = state_q;
        dbl_d   = dbl_q;
        sig_d   = sig_q;
        expo_d  = expo_q;
        mant_d  = mant_q;
        class_d = class_q;
        snan_d  = snan_q;
        qnan_d  = qnan_q;
        inf_d   = inf_q;
        zero_d  = zero_q;
        win     = dbl_q ? mant_q[51:44] : mant_q[22:15];
        sh      = 4'd1 + lz8(win);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dbl_d  = dbl_c;
                    sig_d  = sgn_c;
                    snan_d = 1'b0;
                    qnan_d = 1'b0;
                    inf_d  = 1'b0;
                    zero_d = 1'b0;
                    state_d = DONE;
                    if (ex_c == emax_c) begin
                        expo_d = EW'(ex_c);
                        if (fr_c == 52'd0) begin
                            inf_d   = 1'b1;
                            mant_d  = '0;
                            class_d = CW'(1) << (sgn_c ? 4'd0 : 4'd7);
                        end else begin
                            mant_d  = MW'(fr_c);
                            qnan_d  = fmsb_c;
                            snan_d  = ~fmsb_c;
                            class_d = CW'(1) << (fmsb_c ? 4'd9 : 4'd8);
                        end
                    end else if (ex_c == 11'd0) begin
                        if (fr_c == 52'd0) begin
                            zero_d  = 1'b1;
                            expo_d  = '0;
                            mant_d  = '0;
                            class_d = CW'(1) << (sgn_c ? 4'd3 : 4'd4);
                        end else begin
                            expo_d  = EW'(1);
                            mant_d  = MW'(fr_c);
                            class_d = CW'(1) << (sgn_c ? 4'd2 : 4'd5);
                            state_d = NORM;
                        end
                    end else begin
                        expo_d  = EW'(ex_c);
                        mant_d  = MW'(fr_c) | (dbl_c ? HID_D : HID_S);
                        class_d = CW'(1) << (sgn_c ? 4'd1 : 4'd6);
                    end
                end
            end
            NORM: begin
                if (win == 8'd0) begin
                    mant_d = mant_q << 8;
                    expo_d = expo_q - EW'(8);
                end else begin
                    mant_d  = mant_q << sh;
                    expo_d  = expo_q - EW'(sh);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dbl_q   <= 1'b0;
            sig_q   <= 1'b0;
            expo_q  <= '0;
            mant_q  <= '0;
            class_q <= '0;
            snan_q  <= 1'b0;
            qnan_q  <= 1'b0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dbl_q   <= dbl_d;
            sig_q   <= sig_d;
            expo_q  <= expo_d;
            mant_q  <= mant_d;
            class_q <= class_d;
            snan_q  <= snan_d;
            qnan_q  <= qnan_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_fp_unpk.sv
// Directed bench for fp_unpk: hand-computed vectors, latency, backpressure
// and reset-during-normalization.
module tb_fp_unpk;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_fmt;
    logic        out_valid;
    logic        out_ready;
    logic        out_sig;
    logic [13:0] out_expo;
    logic [53:0] out_mant;
    logic [9:0]  out_class;
    logic        out_snan, out_qnan, out_inf, out_zero;

    int checks   = 0;
    int failures = 0;

    fp_unpk dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_fmt    (in_fmt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_expo  (out_expo),
        .out_mant  (out_mant),
        .out_class (out_class),
        .out_snan  (out_snan),
        .out_qnan  (out_qnan),
        .out_inf   (out_inf),
        .out_zero  (out_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept one operand, measure latency to out_valid, check fields, then drain.
    task automatic run_op(input string tag, input logic [63:0] d, input logic [1:0] f,
                          input int exp_lat, input logic s, input logic [13:0] e,
                          input logic [53:0] m, input logic [9:0] c, input logic [3:0] fl);
        int lat;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_fmt   = f;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            lat++;
            if (out_valid) break;
            tick();
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".sig"}, 64'(out_sig), 64'(s));
        chk({tag, ".expo"}, 64'(out_expo), 64'(e));
        chk({tag, ".mant"}, 64'(out_mant), 64'(m));
        chk({tag, ".class"}, 64'(out_class), 64'(c));
        chk({tag, ".flags"}, 64'({out_snan, out_qnan, out_inf, out_zero}), 64'(fl));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".drain_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_fmt    = 2'd0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd0);
        chk("reset.expo", 64'(out_expo), 64'd0);
        chk("reset.mant", 64'(out_mant), 64'd0);
        chk("reset.class", 64'(out_class), 64'd0);
        reset = 1'b0;
        #1;
        chk("reset.release_ready", 64'(in_ready), 64'd1);

        // Flags are packed {snan, qnan, inf, zero}.
        run_op("s_one", 64'h0000_0000_3F80_0000, 2'd0, 1, 1'b0, 14'd127,
               54'h80_0000, 10'h040, 4'b0000);
        run_op("s_one_fmt2", 64'hDEAD_BEEF_3F80_0000, 2'd2, 1, 1'b0, 14'd127,
               54'h80_0000, 10'h040, 4'b0000);
        run_op("s_minsub", 64'h0000_0000_0000_0001, 2'd0, 4, 1'b0, 14'h3FEA,
               54'h80_0000, 10'h020, 4'b0000);
        run_op("d_negminsub", 64'h8000_0000_0000_0001, 2'd1, 8, 1'b1, 14'h3FCD,
               54'h10_0000_0000_0000, 10'h004, 4'b0000);
        run_op("d_snan", 64'h7FF0_0000_0000_0001, 2'd1, 1, 1'b0, 14'd2047,
               54'h1, 10'h100, 4'b1000);
        run_op("d_qnan", 64'h7FF8_0000_0000_0000, 2'd1, 1, 1'b0, 14'd2047,
               54'h08_0000_0000_0000, 10'h200, 4'b0100);
        run_op("s_negzero", 64'h0000_0000_8000_0000, 2'd0, 1, 1'b1, 14'd0,
               54'h0, 10'h008, 4'b0001);
        run_op("s_neginf", 64'h0000_0000_FF80_0000, 2'd0, 1, 1'b1, 14'd255,
               54'h0, 10'h001, 4'b0010);
        // 0x00400000: msb of f at bit 22, one NORM cycle, expo 0.
        run_op("s_bigsub", 64'h0000_0000_0040_0000, 2'd0, 2, 1'b0, 14'd0,
               54'h80_0000, 10'h020, 4'b0000);

        // Backpressure: result must hold and a second operand must be ignored.
        in_valid = 1'b1;
        in_data  = 64'h0000_0000_3F80_0000;
        in_fmt   = 2'd0;
        tick();
        in_valid = 1'b0;
        chk("bp.first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h0000_0000_4000_0000;
            tick();
            chk("bp.hold_valid", 64'(out_valid), 64'd1);
            chk("bp.in_ready_low", 64'(in_ready), 64'd0);
            chk("bp.hold_expo", 64'(out_expo), 64'd127);
            chk("bp.hold_mant", 64'(out_mant), 64'h80_0000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.release_valid", 64'(out_valid), 64'd0);
        chk("bp.release_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp.no_second_valid", 64'(out_valid), 64'd0);
        chk("bp.no_second_expo", 64'(out_expo), 64'd127);

        // Reset while normalizing a double subnormal.
        in_valid = 1'b1;
        in_data  = 64'h0000_0000_0000_0001;
        in_fmt   = 2'd1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rnorm.busy_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        chk("rnorm.out_valid", 64'(out_valid), 64'd0);
        chk("rnorm.in_ready_in_reset", 64'(in_ready), 64'd0);
        chk("rnorm.expo", 64'(out_expo), 64'd0);
        chk("rnorm.mant", 64'(out_mant), 64'd0);
        chk("rnorm.class", 64'(out_class), 64'd0);
        reset = 1'b0;
        #1;
        chk("rnorm.ready_after", 64'(in_ready), 64'd1);
        run_op("d_one", 64'h3FF0_0000_0000_0000, 2'd1, 1, 1'b0, 14'd1023,
               54'h10_0000_0000_0000, 10'h040, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_unpk.md
# fp_unpk

Sequential floating-point unpacker: accepts a packed IEEE-754 single or double operand and produces the sign, exponent, mantissa and classification used by the FPU arithmetic units. Subnormal operands are normalized with an iterative left shift. The output field layout matches what the rounding/packing stage consumes, so the two blocks form the front and back ends of the FPU datapath. Valid/ready handshakes on both sides.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- in_data  in  64  packed operand; single uses [31:0], [63:32] ignored
- in_fmt  in  2  0 = single, 1 = double, 2/3 = treated as single
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sig  out  1  sign
- out_expo  out  14  exponent, two's complement, biased in operand format
- out_mant  out  54  mantissa; hidden bit at H (H = 23 single, 52 double); bits above H are zero
- out_class  out  10  RISC-V fclass one-hot
- out_snan, out_qnan, out_inf, out_zero  out  1 each  special-case flags

## Operation
- States: IDLE, NORM, DONE.
- in_ready = (state == IDLE) & ~reset. A handshake occurs on the edge where in_valid & in_ready.
- On accept, fields are decoded as e = exponent field and f = fraction field:
  - Normal (e ≠ 0, e ≠ max): expo = e, mant = {hidden 1, f} → DONE.
  - Zero (e = 0, f = 0): expo = 0, mant = 0, zero = 1 → DONE.
  - Inf (e = max, f = 0): expo = max (255 or 2047), mant = 0, inf = 1 → DONE.
  - NaN (e = max, f ≠ 0): expo = max, mant = f. qnan = f[H-1], snan = ~f[H-1] → DONE.
  - Subnormal (e = 0, f ≠ 0): expo = 1, mant = f with bit H = 0 → NORM.
- NORM, applied each cycle to the window w = mant[H-1:H-8]:
  - If w == 0: shift mant left by 8, expo -= 8, stay in NORM.
  - Otherwise: shift mant left by 1 + lz(w) and subtract the same amount from expo, where lz(w) counts leading zeros of w (0..7). Go to DONE.
- Final subnormal result: mant[H] = 1, expo = 1 − s, where s = H − msb(f). NORM occupancy is floor((s−1)/8)+1 cycles: at most 3 for single, 7 for double.
- out_class bits:
  - 0: −inf
  - 1: −normal
  - 2: −subnormal
  - 3: −zero
  - 4: +zero
  - 5: +subnormal
  - 6: +normal
  - 7: +inf
  - 8: sNaN
  - 9: qNaN
- Classification and flags are captured at accept and held through NORM.
- DONE: out_valid = 1. When out_valid & out_ready → IDLE. DONE is left only through the handshake, so it never accepts a new operand in the same cycle.
- All outputs are registered. They hold stable while out_valid = 1 and out_ready = 0.

## Timing
- The accept edge is cycle 0.
- Non-subnormal: out_valid is high from cycle 1.
- Subnormal: out_valid is high from cycle 1 + k, where k = NORM cycles.
- After the output handshake at cycle n, the state is IDLE at cycle n+1 and in_ready = 1 there. Throughput is at most one operand per 2 cycles.
- Reset, whether from IDLE, NORM or DONE: on the next edge the state is IDLE, out_valid = 0, and all data, class and flag outputs are 0. in_ready = 0 while reset is high.
- in_valid while the state is not IDLE has no effect.
- out_ready while out_valid = 0 has no effect.

## Test plan
- Single 1.0, in_data = 0x3F800000, fmt 0 → out_valid at cycle 1; sig 0, expo 127, mant 0x800000, class bit 6, all flags 0.
- Single minimum subnormal 0x00000001 → 3 NORM cycles, out_valid at cycle 4; expo 14'h3FEA (−22), mant 0x800000, class bit 5.
- Double −minimum subnormal 0x8000000000000001, fmt 1 → 7 NORM cycles, out_valid at cycle 8; sig 1, expo 14'h3FCD (−51), mant 0x10000000000000, class bit 2.
- Specials:
  - 0x7FF0000000000001 (fmt 1) → snan 1, class bit 8, expo 2047.
  - 0x7FF8000000000000 → qnan 1, class bit 9.
  - Single 0x80000000 → zero 1, class bit 3.
  - Single 0xFF800000 → inf 1, class bit 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid and pulse in_valid meanwhile → outputs stable, in_ready 0, the second operand is not captured. Raise out_ready → IDLE the next cycle, in_ready = 1.
- Reset during NORM with double subnormal 0x0000000000000001 → next cycle out_valid 0, in_ready 1 after reset drops; a following 0x3FF0000000000000 yields expo 1023, mant 0x10000000000000 at cycle 1.
